// File: rtl/seq_job_arbiter.sv
// seq_job_arbiter: forwards whole jobs from NUM_LANES lanes, in lane rotation order, into one seq_serializer port via a single output register.
// Define SEQ_ARB_PERF_EN to add the perf_* counters and the perf_clear input.
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 16
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 16
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_job_arbiter #(
  parameter int NUM_LANES     = 4,
  parameter int LANE_IDX_BITS = $clog2(NUM_LANES)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  cfg_enable,
  input  logic [NUM_LANES-1:0]                  cfg_lane_mask,
  input  logic [NUM_LANES-1:0]                  lane_valid,
  input  logic [NUM_LANES*`SEQ_LL_BITS-1:0]     lane_ll,
  input  logic [NUM_LANES*`SEQ_ML_BITS-1:0]     lane_ml,
  input  logic [NUM_LANES*`SEQ_OFFSET_BITS-1:0] lane_offset,
  input  logic [NUM_LANES-1:0]                  lane_eoj,
  input  logic [NUM_LANES*`SEQ_ML_BITS-1:0]     lane_overlap_len,
  input  logic [NUM_LANES-1:0]                  lane_delim,
  output logic [NUM_LANES-1:0]                  lane_ready,
  output logic                                  o_valid,
  output logic [`SEQ_LL_BITS-1:0]               o_ll,
  output logic [`SEQ_ML_BITS-1:0]               o_ml,
  output logic [`SEQ_OFFSET_BITS-1:0]           o_offset,
  output logic                                  o_eoj,
  output logic [`SEQ_ML_BITS-1:0]               o_overlap_len,
  output logic                                  o_delim,
  input  logic                                  o_ready,
  output logic [LANE_IDX_BITS-1:0]              o_cur_lane,
  output logic                                  o_job_done,
  output logic [LANE_IDX_BITS-1:0]              o_job_done_lane
`ifdef SEQ_ARB_PERF_EN
  ,
  input  logic                                  perf_clear,
  output logic [31:0]                           perf_jobs,
  output logic [31:0]                           perf_seqs,
  output logic [31:0]                           perf_starve,
  output logic [31:0]                           perf_backpress
`endif
);
  localparam int LW = `SEQ_LL_BITS;
  localparam int MW = `SEQ_ML_BITS;
  localparam int OW = `SEQ_OFFSET_BITS;
  typedef enum logic {S_GRANT, S_HALT} state_t;
  state_t state_q, state_d;
  logic [LANE_IDX_BITS-1:0] cur_lane_q, cur_lane_d, done_lane_q, done_lane_d, low_lane, next_lane;
  logic [2*NUM_LANES-1:0] rot;
  int nxt;
  logic in_job_q, in_job_d, valid_q, valid_d, eoj_q, eoj_d, delim_q, delim_d, done_q, done_d;
  logic [LW-1:0] ll_q, ll_d;
  logic [MW-1:0] ml_q, ml_d, ovl_q, ovl_d;
  logic [OW-1:0] off_q, off_d;
  logic mask_ok, load, realign, accept, sel_eoj, sel_delim;

  always_comb begin
    low_lane = '0;
    for (int i = NUM_LANES-1; i >= 0; i--) if (cfg_lane_mask[i]) low_lane = LANE_IDX_BITS'(i);
  end

  // Rotating the doubled mask puts the lanes after cur_lane at bits 1..NUM_LANES-1.
  always_comb begin
    rot = {cfg_lane_mask, cfg_lane_mask} >> cur_lane_q;
    nxt = int'(cur_lane_q);
    for (int i = NUM_LANES-1; i >= 1; i--) if (rot[i]) nxt = int'(cur_lane_q) + i;
    next_lane = LANE_IDX_BITS'(nxt >= NUM_LANES ? nxt - NUM_LANES : nxt);
  end

  // A lane dropped from the mask keeps its grant until its job ends; only between jobs is it moved.
  always_comb begin
    mask_ok = |cfg_lane_mask;
    load = !valid_q | o_ready;
    realign = !in_job_q & !cfg_lane_mask[cur_lane_q] & mask_ok;
    lane_ready = (state_q == S_GRANT & cfg_enable & mask_ok & !realign & load) ? NUM_LANES'(1) << cur_lane_q : '0;
    accept = lane_valid[cur_lane_q] & lane_ready[cur_lane_q];
    sel_eoj = lane_eoj[cur_lane_q];
    sel_delim = lane_delim[cur_lane_q];
    state_d = (cfg_enable & mask_ok) ? S_GRANT : S_HALT;
    valid_d = load ? accept : valid_q;
    ll_d = accept ? lane_ll[cur_lane_q*LW +: LW] : ll_q;
    ml_d = accept ? lane_ml[cur_lane_q*MW +: MW] : ml_q;
    off_d = accept ? lane_offset[cur_lane_q*OW +: OW] : off_q;
    ovl_d = accept ? lane_overlap_len[cur_lane_q*MW +: MW] : ovl_q;
    eoj_d = accept ? sel_eoj : eoj_q;
    delim_d = accept ? sel_delim : delim_q;
    done_d = accept & sel_eoj;
    done_lane_d = done_d ? cur_lane_q : done_lane_q;
    in_job_d = accept ? !sel_eoj : in_job_q;
    cur_lane_d = realign ? low_lane : done_d ? (sel_delim ? low_lane : next_lane) : cur_lane_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_GRANT;
      cur_lane_q <= '0;
      in_job_q <= 1'b0;
      valid_q <= 1'b0;
      ll_q <= '0;
      ml_q <= '0;
      off_q <= '0;
      ovl_q <= '0;
      eoj_q <= 1'b0;
      delim_q <= 1'b0;
      done_q <= 1'b0;
      done_lane_q <= '0;
    end else begin
      state_q <= state_d;
      cur_lane_q <= cur_lane_d;
      in_job_q <= in_job_d;
      valid_q <= valid_d;
      ll_q <= ll_d;
      ml_q <= ml_d;
      off_q <= off_d;
      ovl_q <= ovl_d;
      eoj_q <= eoj_d;
      delim_q <= delim_d;
      done_q <= done_d;
      done_lane_q <= done_lane_d;
    end
  end

  assign o_valid = valid_q;
  assign o_ll = ll_q;
  assign o_ml = ml_q;
  assign o_offset = off_q;
  assign o_overlap_len = ovl_q;
  assign o_eoj = eoj_q;
  assign o_delim = delim_q;
  assign o_job_done = done_q;
  assign o_job_done_lane = done_lane_q;
  assign o_cur_lane = realign ? low_lane : cur_lane_q;

  assert property (@(posedge clk) disable iff (!rst_n) !(accept & sel_delim & !sel_eoj))
    else $fatal(1, "seq_job_arbiter: lane_delim accepted without lane_eoj");

`ifdef SEQ_ARB_PERF_EN
  logic [31:0] jobs_q, jobs_d, seqs_q, seqs_d, starve_q, starve_d, bp_q, bp_d;
  always_comb begin
    jobs_d = perf_clear ? '0 : jobs_q + 32'(done_d);
    seqs_d = perf_clear ? '0 : seqs_q + 32'(accept);
    starve_d = perf_clear ? '0 : starve_q + 32'(state_q == S_GRANT & load & !lane_valid[cur_lane_q]);
    bp_d = perf_clear ? '0 : bp_q + 32'(valid_q & !o_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      jobs_q <= '0;
      seqs_q <= '0;
      starve_q <= '0;
      bp_q <= '0;
    end else begin
      jobs_q <= jobs_d;
      seqs_q <= seqs_d;
      starve_q <= starve_d;
      bp_q <= bp_d;
    end
  end
  assign perf_jobs = jobs_q;
  assign perf_seqs = seqs_q;
  assign perf_starve = starve_q;
  assign perf_backpress = bp_q;
`endif
endmodule

// File: doc/seq_job_arbiter.md
Name: seq_job_arbiter

Overview:
- Shares one `seq_serializer` input port between NUM_LANES parallel match-job lanes.
- Forwards whole jobs in strict job order: all sequences of lane k, up to and including its eoj beat, then the next enabled lane (wrapping).
- Block delimiters restart the rotation at the lowest enabled lane.
- Sits between the match-engine lane outputs and the `seq_serializer` i_* port; adds one registered pipeline stage.

Parameters:
- NUM_LANES, 4, number of job lanes (2..16).
- LANE_IDX_BITS, $clog2(NUM_LANES), width of lane index.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  when 0, no new beats are accepted; registered output still drains
- cfg_lane_mask  in  NUM_LANES  bit k=1 means lane k takes part in rotation
- lane_valid  in  NUM_LANES  per-lane beat valid
- lane_ll  in  NUM_LANES*`SEQ_LL_BITS  packed, lane k at [k*W +: W]
- lane_ml  in  NUM_LANES*`SEQ_ML_BITS  packed
- lane_offset  in  NUM_LANES*`SEQ_OFFSET_BITS  packed
- lane_eoj  in  NUM_LANES  last sequence of the job
- lane_overlap_len  in  NUM_LANES*`SEQ_ML_BITS  packed
- lane_delim  in  NUM_LANES  block delimiter (valid only with eoj)
- lane_ready  out  NUM_LANES  per-lane accept
- o_valid, o_ll, o_ml, o_offset, o_eoj, o_overlap_len, o_delim  out  1/`SEQ_LL_BITS/`SEQ_ML_BITS/`SEQ_OFFSET_BITS/1/`SEQ_ML_BITS/1  to serializer
- o_ready  in  1  serializer accept
- o_cur_lane  out  LANE_IDX_BITS  lane currently granted
- o_job_done  out  1  one-cycle pulse: an eoj beat was accepted
- o_job_done_lane  out  LANE_IDX_BITS  lane of that eoj beat

Behaviour:
- Reset (async, rst_n=0): all o_* = 0, lane_ready = 0, cur_lane = lowest set bit of cfg_lane_mask (0 if mask is 0), o_job_done = 0. A reset mid-job discards the output register and any partial job.
- Output stage: single register. load = `(!o_valid | o_ready)`. Full throughput: one beat per cycle with o_ready held high.
- lane_ready[k] = (k==cur_lane) & cfg_enable & cfg_lane_mask_ok & load, where cfg_lane_mask_ok = (mask != 0).
- Accept = lane_valid[cur_lane] & lane_ready[cur_lane]. On accept, the lane's fields are copied into o_* and o_valid=1 next cycle. Latency is 1 cycle.
- If o_ready=1 and there is no accept, o_valid goes to 0. o_* fields hold their last value when not loaded.
- State machine, S_GRANT / S_HALT:
  - S_GRANT: forward beats from cur_lane.
  - On an accepted beat with eoj=1 and delim=0: cur_lane <= next set mask bit after cur_lane, with wrap. If only one bit is set, cur_lane stays the same.
  - On an accepted beat with eoj=1 and delim=1: cur_lane <= lowest set mask bit.
  - Either eoj case pulses o_job_done the next cycle, with o_job_done_lane = the old cur_lane.
  - cfg_enable=0 or mask==0: go to S_HALT. No accepts; o_valid drains normally.
  - S_HALT back to S_GRANT: when cfg_enable=1 and mask!=0. If cur_lane's mask bit is clear, cur_lane <= lowest set bit first, taking 1 cycle with no accept.
- Mask changes take effect only at a job boundary. If the current lane is masked off mid-job, it keeps the grant until its eoj.
- Illegal input: lane_delim=1 with eoj=0 is a simulation $fatal. The beat is still forwarded.
- Backpressure: o_* are stable while o_valid=1 and o_ready=0.
- Widths: the next-lane search is combinational over NUM_LANES. There is no arithmetic on sequence fields.

Optional Feature:
- SEQ_ARB_PERF_EN defined: adds outputs perf_jobs (32b, eoj beats accepted), perf_seqs (32b, beats accepted), perf_starve (32b, cycles in S_GRANT with load=1 and lane_valid[cur_lane]=0) and perf_backpress (32b, cycles with o_valid=1 and o_ready=0).
  - Counters reset to 0 on rst_n and wrap at 2^32.
  - perf_clear (in, 1) zeroes all counters synchronously; a same-cycle increment is lost.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Mask=4'b1111, o_ready=1. Lane0 sends 3 beats (ll=1,2,3, last eoj), lane1 sends 1 eoj beat (ll=7) -> output order ll=1,2,3,7 on consecutive cycles; o_job_done pulses with lane 0, then lane 1; o_cur_lane ends at 2.
- Mask=4'b1010, start after reset -> cur_lane=1. Jobs on lanes 1 then 3 forwarded; lanes 0 and 2 stay valid with lane_ready=0 throughout; after lane 3's eoj, cur_lane wraps to 1.
- Lane2 eoj+delim accepted while cur_lane=2, mask=4'b1111 -> next cur_lane=0, not 3.
- o_ready toggles 1,0,0,1 during a 4-beat job -> no beat lost or duplicated; o_* stable during stall; the 4 beats are delivered in order.
- cfg_enable dropped mid-job on lane 1 -> no accepts, pending o_valid drains. Re-enable -> lane 1 continues its job; a mask bit cleared for lane 1 meanwhile has no effect until its eoj.
- rst_n asserted while o_valid=1, mid-job on lane 2 -> o_valid=0 immediately (async); cur_lane = lowest mask bit after release.
